// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - round-robin arbiter sharing one SCCB/I2C master among NREQ requesters
// Optional feature macro: I2C_ARB_LOCK_EN (req_lock keeps priority on the requester that just completed).
module i2c_cmd_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 20000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_exec,
  input  logic [NREQ*24-1:0]   req_data,
  input  logic [NREQ-1:0]      req_rh_wl,
  input  logic [NREQ-1:0]      req_lock,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic [7:0]           rd_data,
  output logic                 busy,
  output logic                 i2c_exec,
  output logic [23:0]          i2c_data,
  output logic                 i2c_rh_wl,
  input  logic                 i2c_done,
  input  logic [7:0]           i2c_data_r
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          state_q;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [23:0]     cmd_q [NREQ];
  logic [NREQ-1:0] rw_q;
  logic [PW-1:0]   ptr_q, grant_q, sel_idx;
  logic            sel_found;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] req_done_q, req_err_q;
  logic [7:0]      rd_data_q;
  logic            busy_q, i2c_exec_q, i2c_rh_wl_q;
  logic [23:0]     i2c_data_q;
  logic            done_hit, tout_hit;
  logic [NREQ-1:0] clr_mask, accept, overrun;

`ifndef I2C_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  // Index base+k wrapped into 0..NREQ-1.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] g);
    return (g == LAST_IDX) ? '0 : g + 1'b1;
  endfunction

  // Completion and watchdog events for the granted requester; only meaningful in WAIT.
  always_comb begin
    done_hit = (state_q == S_WAIT) && i2c_done;
    tout_hit = (state_q == S_WAIT) && !i2c_done && (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    clr_mask = '0;
    if (done_hit || tout_hit) clr_mask[grant_q] = 1'b1;
  end

  // Capture rules: a requester completing this cycle may re-arm at once (set wins over clear).
  always_comb begin
    accept    = req_exec & (~pending_q | clr_mask);
    overrun   = req_exec & pending_q & ~clr_mask;
    pending_d = (pending_q & ~clr_mask) | accept;
  end

  // Round-robin pick: first pending index at or after ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!sel_found && pending_q[wrap_idx(ptr_q, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_idx(ptr_q, k);
      end
    end
  end

  // Per-requester command latches and pending flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      rw_q      <= '0;
      for (int i = 0; i < NREQ; i++) cmd_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) begin
          cmd_q[i] <= req_data[24*i +: 24];
          rw_q[i]  <= req_rh_wl[i];
        end
      end
    end
  end

  // Arbitration FSM with registered master-side and requester-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      req_done_q  <= '0;
      req_err_q   <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      i2c_exec_q  <= 1'b0;
      i2c_data_q  <= '0;
      i2c_rh_wl_q <= 1'b1;
    end else begin
      i2c_exec_q <= 1'b0;
      req_done_q <= done_hit ? clr_mask : '0;
      req_err_q  <= overrun | (tout_hit ? clr_mask : '0);
      case (state_q)
        S_IDLE: begin
          busy_q <= sel_found | (|pending_d);
          if (sel_found) begin
            grant_q     <= sel_idx;
            i2c_data_q  <= cmd_q[sel_idx];
            i2c_rh_wl_q <= rw_q[sel_idx];
            i2c_exec_q  <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          busy_q <= (done_hit || tout_hit) ? (|pending_d) : 1'b1;
          if (done_hit) begin
            if (i2c_rh_wl_q) rd_data_q <= i2c_data_r;
`ifdef I2C_ARB_LOCK_EN
            ptr_q <= req_lock[grant_q] ? grant_q : next_idx(grant_q);
`else
            ptr_q <= next_idx(grant_q);
`endif
            state_q <= S_IDLE;
          end else if (tout_hit) begin
            ptr_q   <= next_idx(grant_q);
            state_q <= S_IDLE;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_done  = req_done_q;
  assign req_err   = req_err_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign i2c_exec  = i2c_exec_q;
  assign i2c_data  = i2c_data_q;
  assign i2c_rh_wl = i2c_rh_wl_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb/tb_i2c_cmd_arbiter.sv - directed self-checking bench for i2c_cmd_arbiter
module tb_i2c_cmd_arbiter;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_exec = '0;
  logic [NREQ*24-1:0] req_data = '0;
  logic [NREQ-1:0]   req_rh_wl = '0;
  logic [NREQ-1:0]   req_lock = '0;
  logic [NREQ-1:0]   req_done, req_err;
  logic [7:0]        rd_data;
  logic              busy, i2c_exec, i2c_rh_wl;
  logic [23:0]       i2c_data;
  logic              i2c_done = 1'b0;
  logic [7:0]        i2c_data_r = '0;

  int checks = 0;
  int failures = 0;

  i2c_cmd_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_exec(req_exec), .req_data(req_data),
    .req_rh_wl(req_rh_wl), .req_lock(req_lock), .req_done(req_done), .req_err(req_err),
    .rd_data(rd_data), .busy(busy), .i2c_exec(i2c_exec), .i2c_data(i2c_data),
    .i2c_rh_wl(i2c_rh_wl), .i2c_done(i2c_done), .i2c_data_r(i2c_data_r)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [23:0] d, input logic rw);
    req_data[24*i +: 24] = d;
    req_rh_wl[i] = rw;
  endtask

  task automatic wait_exec(input string nm);
    int n = 0;
    while (i2c_exec !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (i2c_exec !== 1'b1) begin
      failures++;
      $display("FAIL %s_exec_wait: i2c_exec=%b after %0d cycles, required 1", nm, i2c_exec, n);
    end
  endtask

  task automatic pulse_done(input logic [7:0] rdv);
    repeat (3) step();
    i2c_data_r = rdv;
    i2c_done = 1'b1;
    step();
    i2c_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (i2c_exec !== 1'b0) begin failures++; $display("FAIL rst_exec: got %b required 0", i2c_exec); end
    checks++; if (i2c_data !== 24'h0) begin failures++; $display("FAIL rst_data: got %h required 000000", i2c_data); end
    checks++; if (i2c_rh_wl !== 1'b1) begin failures++; $display("FAIL rst_rh_wl: got %b required 1", i2c_rh_wl); end
    checks++; if (req_done !== 3'b000) begin failures++; $display("FAIL rst_done: got %b required 000", req_done); end
    checks++; if (req_err !== 3'b000) begin failures++; $display("FAIL rst_err: got %b required 000", req_err); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rst_rd_data: got %h required 00", rd_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    set_cmd(0, 24'h300882, 1'b0);
    req_exec = 3'b001;
    step();
    req_exec = '0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy_rise: got %b required 1", busy); end
    checks++; if (i2c_exec !== 1'b0) begin failures++; $display("FAIL wr_exec_early: got %b required 0", i2c_exec); end
    step();
    checks++; if (i2c_exec !== 1'b1) begin failures++; $display("FAIL wr_exec_lat2: got %b required 1", i2c_exec); end
    checks++; if (i2c_data !== 24'h300882) begin failures++; $display("FAIL wr_data: got %h required 300882", i2c_data); end
    checks++; if (i2c_rh_wl !== 1'b0) begin failures++; $display("FAIL wr_rh_wl: got %b required 0", i2c_rh_wl); end
    repeat (40) step();
    checks++; if (i2c_data !== 24'h300882) begin failures++; $display("FAIL wr_data_hold: got %h required 300882", i2c_data); end
    i2c_done = 1'b1;
    step();
    i2c_done = 1'b0;
    checks++; if (req_done !== 3'b001) begin failures++; $display("FAIL wr_done: got %b required 001", req_done); end
    checks++; if (req_err !== 3'b000) begin failures++; $display("FAIL wr_err: got %b required 000", req_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_fall: got %b required 0", busy); end
    step();
    checks++; if (req_done !== 3'b000) begin failures++; $display("FAIL wr_done_width: got %b required 000", req_done); end
  endtask

  task automatic test_read();
    set_cmd(1, 24'h300A00, 1'b1);
    req_exec = 3'b010;
    step();
    req_exec = '0;
    wait_exec("rd");
    checks++; if (i2c_rh_wl !== 1'b1) begin failures++; $display("FAIL rd_rh_wl: got %b required 1", i2c_rh_wl); end
    checks++; if (i2c_data !== 24'h300A00) begin failures++; $display("FAIL rd_data_out: got %h required 300a00", i2c_data); end
    pulse_done(8'h56);
    checks++; if (rd_data !== 8'h56) begin failures++; $display("FAIL rd_data: got %h required 56", rd_data); end
    checks++; if (req_done !== 3'b010) begin failures++; $display("FAIL rd_done: got %b required 010", req_done); end
  endtask

  task automatic test_overrun();
    set_cmd(0, 24'h350307, 1'b0);
    req_exec = 3'b001;
    step();
    req_exec = '0;
    wait_exec("ovr_r0");
    set_cmd(2, 24'h380800, 1'b0);
    req_exec = 3'b100;
    step();
    checks++; if (req_err !== 3'b000) begin failures++; $display("FAIL ovr_first_err: got %b required 000", req_err); end
    set_cmd(2, 24'h3808FF, 1'b1);
    step();
    req_exec = '0;
    checks++; if (req_err !== 3'b100) begin failures++; $display("FAIL ovr_err: got %b required 100", req_err); end
    step();
    checks++; if (req_err !== 3'b000) begin failures++; $display("FAIL ovr_err_width: got %b required 000", req_err); end
    pulse_done(8'h00);
    checks++; if (req_done !== 3'b001) begin failures++; $display("FAIL ovr_done0: got %b required 001", req_done); end
    wait_exec("ovr_r2");
    checks++; if (i2c_data !== 24'h380800) begin failures++; $display("FAIL ovr_kept_data: got %h required 380800", i2c_data); end
    checks++; if (i2c_rh_wl !== 1'b0) begin failures++; $display("FAIL ovr_kept_rw: got %b required 0", i2c_rh_wl); end
    pulse_done(8'h00);
    checks++; if (req_done !== 3'b100) begin failures++; $display("FAIL ovr_done2: got %b required 100", req_done); end
  endtask

  task automatic test_contention();
    logic [23:0] exp_w [3];
    exp_w[0] = 24'h310000;
    exp_w[1] = 24'h320111;
    exp_w[2] = 24'h330222;
    for (int i = 0; i < 3; i++) set_cmd(i, exp_w[i], 1'b0);
    for (int r = 0; r < 2; r++) begin
      req_exec = 3'b111;
      step();
      req_exec = '0;
      for (int j = 0; j < 3; j++) begin
        wait_exec("cont");
        checks++; if (i2c_data !== exp_w[j]) begin failures++; $display("FAIL cont_order r%0d j%0d: got %h required %h", r, j, i2c_data, exp_w[j]); end
        step();
        checks++; if (i2c_exec !== 1'b0) begin failures++; $display("FAIL cont_exec_width r%0d j%0d: got %b required 0", r, j, i2c_exec); end
        repeat (3) begin
          step();
          checks++; if (i2c_data !== exp_w[j]) begin failures++; $display("FAIL cont_hold r%0d j%0d: got %h required %h", r, j, i2c_data, exp_w[j]); end
        end
        i2c_done = 1'b1;
        step();
        i2c_done = 1'b0;
        checks++; if (req_done !== 3'(1 << j)) begin failures++; $display("FAIL cont_done r%0d j%0d: got %b required %b", r, j, req_done, 3'(1 << j)); end
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    set_cmd(0, 24'h3A0011, 1'b0);
    set_cmd(1, 24'h3A0122, 1'b0);
    req_exec = 3'b011;
    step();
    req_exec = '0;
    wait_exec("to");
    checks++; if (i2c_data !== 24'h3A0011) begin failures++; $display("FAIL to_first: got %h required 3a0011", i2c_data); end
    while (req_err === 3'b000 && n < 200) begin
      step();
      n++;
    end
    checks++; if (n != TIMEOUT + 1) begin failures++; $display("FAIL to_latency: got %0d cycles required %0d", n, TIMEOUT + 1); end
    checks++; if (req_err !== 3'b001) begin failures++; $display("FAIL to_err: got %b required 001", req_err); end
    i2c_done = 1'b1;
    step();
    checks++; if (i2c_exec !== 1'b1) begin failures++; $display("FAIL to_next_exec: got %b required 1", i2c_exec); end
    checks++; if (i2c_data !== 24'h3A0122) begin failures++; $display("FAIL to_next_data: got %h required 3a0122", i2c_data); end
    checks++; if (req_done !== 3'b000) begin failures++; $display("FAIL to_stray_idle: got %b required 000", req_done); end
    step();
    i2c_done = 1'b0;
    checks++; if (req_done !== 3'b000) begin failures++; $display("FAIL to_stray_issue: got %b required 000", req_done); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL to_busy: got %b required 1", busy); end
    pulse_done(8'h00);
    checks++; if (req_done !== 3'b010) begin failures++; $display("FAIL to_done1: got %b required 010", req_done); end
  endtask

  task automatic test_back_to_back();
    set_cmd(1, 24'h3B0001, 1'b0);
    req_exec = 3'b010;
    step();
    req_exec = '0;
    wait_exec("b2b");
    repeat (3) step();
    set_cmd(1, 24'h3B0002, 1'b1);
    req_exec = 3'b010;
    i2c_done = 1'b1;
    step();
    req_exec = '0;
    i2c_done = 1'b0;
    checks++; if (req_done !== 3'b010) begin failures++; $display("FAIL b2b_done: got %b required 010", req_done); end
    checks++; if (req_err !== 3'b000) begin failures++; $display("FAIL b2b_no_overrun: got %b required 000", req_err); end
    step();
    checks++; if (i2c_exec !== 1'b1) begin failures++; $display("FAIL b2b_exec_lat: got %b required 1", i2c_exec); end
    checks++; if (i2c_data !== 24'h3B0002) begin failures++; $display("FAIL b2b_data: got %h required 3b0002", i2c_data); end
    pulse_done(8'hA5);
    checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL b2b_rd_data: got %h required a5", rd_data); end
  endtask

  task automatic test_lock();
    int exp_id [4];
    logic [23:0] w [2];
`ifdef I2C_ARB_LOCK_EN
    exp_id = '{0, 0, 0, 1};
`else
    exp_id = '{0, 1, 0, 1};
`endif
    w[0] = 24'h3C0000;
    w[1] = 24'h3D0101;
    set_cmd(0, w[0], 1'b0);
    set_cmd(1, w[1], 1'b0);
    req_lock = 3'b001;
    req_exec = 3'b011;
    step();
    req_exec = '0;
    for (int k = 0; k < 4; k++) begin
      wait_exec("lock");
      checks++; if (i2c_data !== w[exp_id[k]]) begin failures++; $display("FAIL lock_order k%0d: got %h required %h", k, i2c_data, w[exp_id[k]]); end
      if (k == 2) req_lock = '0;
      repeat (3) step();
      i2c_done = 1'b1;
      if (k < 3) req_exec = 3'(1 << exp_id[k]);
      step();
      i2c_done = 1'b0;
      req_exec = '0;
    end
    wait_exec("lock_drain");
    checks++; if (i2c_data !== w[0]) begin failures++; $display("FAIL lock_drain: got %h required %h", i2c_data, w[0]); end
    pulse_done(8'h00);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL lock_idle: got %b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_overrun();
    test_contention();
    test_timeout();
    test_back_to_back();
    test_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
